velocity_cell_pingpong: RTL and testbench
=========================================

# velocity_cell_pingpong

Parametrised per-cell velocity store with two ping-pong banks, for the range-limited MD pipeline. The active bank serves velocity reads to force evaluation and motion update. The shadow bank takes newly computed velocities from the motion-update unit. A single-cycle swap makes the new velocities active at the iteration boundary. It sits between the velocity cache and the motion-update unit, one instance per cell, and replaces single-bank velocity memories.

## Interface
- DATA_WIDTH, 96: word width, packed {vz, vy, vx}, 32-bit float each
- PARTICLE_NUM, 220: words per bank; address 0 holds the particle count, 1..PARTICLE_NUM-1 hold particles
- ADDR_WIDTH, 8: address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read request on active bank
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data valid
- wr_en  in  1  write request to shadow bank
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- swap_req  in  1  single-cycle pulse: exchange active/shadow
- swap_done  out  1  pulse, cycle the swap takes effect
- bank_sel  out  1  index of active bank
- wr_count  out  ADDR_WIDTH+1  accepted writes to shadow since last swap/reset
- ready  out  1  block accepts requests
- err_oob  out  1  sticky out-of-range access flag

## Operation
- The FSM has three states: INIT, RUN and SWAP.
- Reset drives the FSM to INIT.
  - With VELOCITY_CELL_ZERO_INIT_EN, INIT sweeps addresses 0..PARTICLE_NUM-1 in both banks, writing zero, one address per cycle, then moves to RUN.
  - Without the macro, INIT moves to RUN after one cycle.
- ready=1 only in RUN and SWAP.
- While ready=0, rd_en, wr_en and swap_req are ignored. No rd_valid is produced, no write occurs and wr_count does not change.
- RUN:
  - A read accesses bank bank_sel.
  - A write accesses bank ~bank_sel and increments wr_count.
  - Because the two ports always target different banks, a read and a write in the same cycle never conflict.
- swap_req in RUN:
  - A write in the same cycle still lands in the old shadow bank and is counted.
  - A read in the same cycle uses the old active bank.
  - The FSM enters SWAP for the next cycle. In that cycle bank_sel has toggled, swap_done=1 and wr_count=0.
  - SWAP accepts reads and writes against the new bank assignment and returns to RUN.
  - swap_req in SWAP is ignored.
- Out-of-range addresses (>= PARTICLE_NUM):
  - A write is dropped and does not increment wr_count.
  - A read returns zero with rd_valid=1.
  - Either case sets err_oob, which stays set until rst.
- Address 0 is an ordinary word. Software convention stores the count in bits [ADDR_WIDTH-1:0].
- wr_count saturates at 2^(ADDR_WIDTH+1)-1.
- rst during any state:
  - Aborts in-flight reads (rd_valid forced to 0).
  - Returns the FSM to INIT.
  - Memory contents are retained unless ZERO_INIT reclears them.

## Timing
- Read latency is 2 cycles: rd_en at edge N gives rd_data/rd_valid at edge N+2. The address is registered, then the RAM output is registered.
- A read in flight across a swap returns data from the bank selected at issue.
- Writes are visible to reads only after a swap. The earliest read is the cycle after swap_done.
- Reset values: rd_data=0, rd_valid=0, swap_done=0, bank_sel=0, wr_count=0, ready=0, err_oob=0.
- ready rises PARTICLE_NUM+1 cycles after rst deasserts with ZERO_INIT, and 1 cycle after without it.
- Throughput is one read plus one write per cycle, including the SWAP cycle.

## Configuration
- VELOCITY_CELL_ZERO_INIT_EN
  - Defined: the INIT sweep is compiled in, so both banks read as zero after every reset.
  - Undefined: no sweep logic, and contents after reset are those from power-up or the previous run.

## Structure
- Shared package velocity_cell_pkg holds:
  - the velocity word layout constants (VX/VY/VZ bit offsets, FLOAT_WIDTH=32)
  - the FSM state encoding
  - the OOB check function
- Sub-module velocity_bank_ram: one single-port M20K bank with 2-cycle registered read, parametrised by DATA_WIDTH/PARTICLE_NUM/ADDR_WIDTH, instantiated twice.
- The top level contains the port-to-bank muxing, the FSM, counters and the read valid pipeline.

## Test plan
- Reset with ZERO_INIT, PARTICLE_NUM=220 -> ready=0 for 221 cycles. Afterwards, reads of addr 0, 1 and 219 return 0 with rd_valid two cycles after rd_en.
- Write addr 1 = 0x3F800000_40000000_40400000, then read addr 1 before swap -> returns 0 and wr_count=1. Pulse swap_req, read addr 1 -> returns the written value, bank_sel=1, wr_count=0.
- swap_req and wr_en(addr 2, value X) in the same cycle, with rd_en(addr 2) -> the read returns the pre-swap value. After swap_done, a read of addr 2 returns X.
- Write addr 220 and read addr 255 -> the write is dropped (wr_count unchanged), the read returns 0 with rd_valid, and err_oob=1 persists until rst.
- rst asserted mid-sweep and with a read in flight -> rd_valid=0 the next cycle, bank_sel=0, INIT restarts and the full sweep completes.
- Back-to-back swap_req on two consecutive cycles -> exactly one swap_done; the second request is ignored and bank_sel toggles once.

Source files
------------

// File: rtl/velocity_cell_pkg.sv
// Shared definitions for the ping-pong per-cell velocity store.
// Holds the velocity word layout, the FSM state encoding and the address range check.
package velocity_cell_pkg;

  // Velocity word layout: {vz, vy, vx}, one single-precision float each
  localparam int FLOAT_WIDTH = 32;
  localparam int VX_LSB      = 0;
  localparam int VY_LSB      = VX_LSB + FLOAT_WIDTH;
  localparam int VZ_LSB      = VY_LSB + FLOAT_WIDTH;

  // Controller states
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  // True when an address falls outside the populated part of a bank
  function automatic logic addr_oob(input logic [31:0] addr, input logic [31:0] limit);
    return (addr >= limit);
  endfunction

endpackage

// File: rtl/velocity_bank_ram.sv
// One single-port velocity bank. Requests are registered in stage p0 and the
// memory is accessed in stage p1, so read data appears two edges after the request.
module velocity_bank_ram
  import velocity_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [PARTICLE_NUM];
  logic                  r_en_p0;
  logic                  r_we_p0;
  logic [ADDR_WIDTH-1:0] r_addr_p0;
  logic [DATA_WIDTH-1:0] r_wdata_p0;
  logic [DATA_WIDTH-1:0] r_q_p1;

  // Stage p0: register request control (reset drops any pending access)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_p0 <= 1'b0;
      r_we_p0 <= 1'b0;
    end else begin
      r_en_p0 <= i_en;
      r_we_p0 <= i_we;
    end
  end

  // Stage p0: register address and write data
  always_ff @(posedge clk) begin
    r_addr_p0  <= i_addr;
    r_wdata_p0 <= i_wdata;
  end

  // Stage p1: single-port memory access with registered read output
  always_ff @(posedge clk) begin
    if (r_en_p0) begin
      if (r_we_p0) begin
        r_mem[r_addr_p0] <= r_wdata_p0;
      end else begin
        r_q_p1 <= r_mem[r_addr_p0];
      end
    end
  end

  assign o_rdata = r_q_p1;

endmodule

// File: rtl/velocity_cell_pingpong.sv
// Per-cell velocity store with two ping-pong banks. Reads hit the active bank,
// writes fill the shadow bank, and a swap request exchanges them at an
// iteration boundary. Optional macro VELOCITY_CELL_ZERO_INIT_EN compiles in a
// post-reset sweep that clears both banks.
module velocity_cell_pingpong
  import velocity_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  bank_sel,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  ready,
  output logic                  err_oob
);

  localparam logic [ADDR_WIDTH:0] WC_MAX = {(ADDR_WIDTH+1){1'b1}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_ready;
  logic                  w_swap_done;
  logic                  w_do_swap;
  logic                  r_bank_sel;
  logic [ADDR_WIDTH:0]   r_wr_count;
  logic                  r_err_oob;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_rd_oob;
  logic                  w_wr_oob;
  logic                  w_rd_ram;
  logic                  w_wr_ram;

  logic                  w_sweep;
  logic [ADDR_WIDTH-1:0] w_sweep_addr;

  logic                  w_en0, w_we0, w_en1, w_we1;
  logic [ADDR_WIDTH-1:0] w_addr0, w_addr1;
  logic [DATA_WIDTH-1:0] w_wdata0, w_wdata1;
  logic [DATA_WIDTH-1:0] w_q0, w_q1;

  logic                  r_vld_p0, r_vld_p1;
  logic                  r_oob_p0, r_oob_p1;
  logic                  r_bank_p0, r_bank_p1;

`ifdef VELOCITY_CELL_ZERO_INIT_EN
  localparam logic [ADDR_WIDTH:0] SWEEP_END = (ADDR_WIDTH+1)'(PARTICLE_NUM);
  logic [ADDR_WIDTH:0] r_init_cnt;

  // Sweep address counter; it parks on SWEEP_END for one cycle before RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT && r_init_cnt != SWEEP_END) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  assign w_sweep      = (r_state == ST_INIT) && (r_init_cnt != SWEEP_END);
  assign w_sweep_addr = r_init_cnt[ADDR_WIDTH-1:0];
`else
  assign w_sweep      = 1'b0;
  assign w_sweep_addr = '0;
`endif

  // Request qualification; nothing is accepted while the block is not ready
  assign w_rd_acc = w_ready & rd_en;
  assign w_wr_acc = w_ready & wr_en;
  assign w_rd_oob = addr_oob(32'(rd_addr), 32'(PARTICLE_NUM));
  assign w_wr_oob = addr_oob(32'(wr_addr), 32'(PARTICLE_NUM));
  assign w_rd_ram = w_rd_acc & ~w_rd_oob;
  assign w_wr_ram = w_wr_acc & ~w_wr_oob;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and decoded outputs; swap requests only count in RUN
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_swap_done = 1'b0;
    w_do_swap   = 1'b0;
    case (r_state)
      ST_INIT: begin
`ifdef VELOCITY_CELL_ZERO_INIT_EN
        if (r_init_cnt == SWEEP_END) begin
          w_state_nxt = ST_RUN;
        end
`else
        w_state_nxt = ST_RUN;
`endif
      end
      ST_RUN: begin
        w_ready = 1'b1;
        if (swap_req) begin
          w_do_swap   = 1'b1;
          w_state_nxt = ST_SWAP;
        end
      end
      ST_SWAP: begin
        w_ready     = 1'b1;
        w_swap_done = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Bank select, shadow write counter and sticky range error
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_sel <= 1'b0;
      r_wr_count <= '0;
      r_err_oob  <= 1'b0;
    end else begin
      if (w_do_swap) begin
        r_bank_sel <= ~r_bank_sel;
      end
      // A write in the swap cycle lands in the old shadow; the count restarts
      if (w_do_swap) begin
        r_wr_count <= '0;
      end else if (w_wr_ram && r_wr_count != WC_MAX) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
      if ((w_rd_acc && w_rd_oob) || (w_wr_acc && w_wr_oob)) begin
        r_err_oob <= 1'b1;
      end
    end
  end

  // Port-to-bank steering: reads go to the active bank, writes to the other
  always_comb begin
    w_en0    = 1'b0;
    w_we0    = 1'b0;
    w_addr0  = rd_addr;
    w_wdata0 = wr_data;
    w_en1    = 1'b0;
    w_we1    = 1'b0;
    w_addr1  = rd_addr;
    w_wdata1 = wr_data;
    if (w_sweep) begin
      w_en0    = 1'b1;
      w_we0    = 1'b1;
      w_addr0  = w_sweep_addr;
      w_wdata0 = '0;
      w_en1    = 1'b1;
      w_we1    = 1'b1;
      w_addr1  = w_sweep_addr;
      w_wdata1 = '0;
    end else if (r_bank_sel) begin
      w_en1   = w_rd_ram;
      w_addr1 = rd_addr;
      w_en0   = w_wr_ram;
      w_we0   = 1'b1;
      w_addr0 = wr_addr;
    end else begin
      w_en0   = w_rd_ram;
      w_addr0 = rd_addr;
      w_en1   = w_wr_ram;
      w_we1   = 1'b1;
      w_addr1 = wr_addr;
    end
  end

  velocity_bank_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARTICLE_NUM(PARTICLE_NUM),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en0),
    .i_we   (w_we0),
    .i_addr (w_addr0),
    .i_wdata(w_wdata0),
    .o_rdata(w_q0)
  );

  velocity_bank_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARTICLE_NUM(PARTICLE_NUM),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en1),
    .i_we   (w_we1),
    .i_addr (w_addr1),
    .i_wdata(w_wdata1),
    .o_rdata(w_q1)
  );

  // Read valid pipeline, stage p0 then p1 (reset aborts reads in flight)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p0 <= w_rd_acc;
      r_vld_p1 <= r_vld_p0;
    end
  end

  // Read qualifiers travel with the request so a swap cannot redirect it
  always_ff @(posedge clk) begin
    r_oob_p0  <= w_rd_oob;
    r_bank_p0 <= r_bank_sel;
    r_oob_p1  <= r_oob_p0;
    r_bank_p1 <= r_bank_p0;
  end

  assign rd_valid  = r_vld_p1;
  assign rd_data   = (r_vld_p1 && !r_oob_p1) ? (r_bank_p1 ? w_q1 : w_q0) : '0;
  assign swap_done = w_swap_done;
  assign bank_sel  = r_bank_sel;
  assign wr_count  = r_wr_count;
  assign ready     = w_ready;
  assign err_oob   = r_err_oob;

endmodule

// File: tb/tb_velocity_cell_pingpong.sv
// Directed bench for velocity_cell_pingpong with hand-computed expectations.
module tb_velocity_cell_pingpong;
  import velocity_cell_pkg::*;

  localparam int DW = 96;
  localparam int PN = 220;
  localparam int AW = 8;
`ifdef VELOCITY_CELL_ZERO_INIT_EN
  localparam int INIT_CYC = PN + 1;
`else
  localparam int INIT_CYC = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_done;
  logic          bank_sel;
  logic [AW:0]   wr_count;
  logic          ready;
  logic          err_oob;

  int checks = 0;
  int errors = 0;
  logic exp_bank;
  logic [DW-1:0] v1, vx, vy, vz;

  always #5 clk = ~clk;

  velocity_cell_pingpong #(
    .DATA_WIDTH  (DW),
    .PARTICLE_NUM(PN),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .swap_req (swap_req),
    .swap_done(swap_done),
    .bank_sel (bank_sel),
    .wr_count (wr_count),
    .ready    (ready),
    .err_oob  (err_oob)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk({tag, "_vld_early"}, rd_valid, 1'b0);
    step();
    chk({tag, "_vld"}, rd_valid, 1'b1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  task automatic do_swap(input string tag);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    exp_bank = ~exp_bank;
    chk({tag, "_done"}, swap_done, 1'b1);
    chk({tag, "_bank"}, bank_sel, exp_bank);
    chk({tag, "_wrcnt"}, wr_count, '0);
    step();
    chk({tag, "_done_clr"}, swap_done, 1'b0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk(tag, n, INIT_CYC);
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; swap_req = 1'b0; exp_bank = 1'b0;
    v1 = '0;
    v1[VZ_LSB +: FLOAT_WIDTH] = 32'h3F800000;
    v1[VY_LSB +: FLOAT_WIDTH] = 32'h40000000;
    v1[VX_LSB +: FLOAT_WIDTH] = 32'h40400000;
    vx = 96'h11111111_22222222_33333333;
    vy = 96'hAAAA5555_0000FFFF_12345678;
    vz = 96'hDEADBEEF_CAFEF00D_0BADF00D;

    // Reset values
    repeat (3) step();
    chk("rst_ready", ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_swap_done", swap_done, 1'b0);
    chk("rst_bank_sel", bank_sel, 1'b0);
    chk("rst_wr_count", wr_count, '0);
    chk("rst_err_oob", err_oob, 1'b0);
    rst = 1'b0;
    wait_ready("init_cycles");

    // Put known zeros in both banks at the addresses used below
    do_write(8'd0, '0); do_write(8'd1, '0); do_write(8'd2, '0); do_write(8'd219, '0);
    chk("prep_wrcnt", wr_count, 9'd4);
    do_swap("prep_swap1");
    do_write(8'd0, '0); do_write(8'd1, '0); do_write(8'd2, '0); do_write(8'd219, '0);
    do_swap("prep_swap2");
    do_read("rd0_zero", 8'd0, '0);
    do_read("rd1_zero", 8'd1, '0);
    do_read("rd219_zero", 8'd219, '0);

    // Writes are hidden until the swap
    do_write(8'd1, v1);
    chk("w1_wrcnt", wr_count, 9'd1);
    do_read("rd1_preswap", 8'd1, '0);
    do_swap("swap_v1");
    do_read("rd1_postswap", 8'd1, v1);

    // Put vy in old-active addr 2, then read+write+swap in one cycle
    do_write(8'd2, vy);
    do_swap("swap_vy");
    rd_en = 1'b1; rd_addr = 8'd2;
    wr_en = 1'b1; wr_addr = 8'd2; wr_data = vx;
    swap_req = 1'b1;
    step();
    rd_en = 1'b0; swap_req = 1'b0; exp_bank = 1'b1;
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = vz;
    chk("combo_done", swap_done, 1'b1);
    chk("combo_bank", bank_sel, 1'b1);
    chk("combo_wrcnt", wr_count, '0);
    chk("combo_vld_early", rd_valid, 1'b0);
    step();
    wr_en = 1'b0;
    chk("combo_vld", rd_valid, 1'b1);
    chk("combo_data_preswap", rd_data, vy);
    chk("swapcycle_write_cnt", wr_count, 9'd1);
    chk("combo_done_clr", swap_done, 1'b0);
    do_read("rd2_new", 8'd2, vx);

    // Range boundaries and sticky error
    chk("oob_clear", err_oob, 1'b0);
    do_write(8'd220, vz);
    chk("oob_wr_dropped", wr_count, 9'd1);
    chk("oob_set_wr", err_oob, 1'b1);
    do_write(8'd219, vz);
    chk("last_addr_counted", wr_count, 9'd2);
    do_read("oob_rd255", 8'd255, '0);
    repeat (3) step();
    chk("oob_sticky", err_oob, 1'b1);

    // Back-to-back swap requests yield one swap
    swap_req = 1'b1;
    step();
    chk("b2b_done1", swap_done, 1'b1);
    chk("b2b_bank1", bank_sel, 1'b0);
    step();
    swap_req = 1'b0;
    chk("b2b_done2", swap_done, 1'b0);
    chk("b2b_bank2", bank_sel, 1'b0);
    step();
    chk("b2b_done3", swap_done, 1'b0);
    chk("b2b_bank3", bank_sel, 1'b0);
    exp_bank = 1'b0;

    // Write counter saturation
    for (int i = 0; i < 515; i++) do_write(8'd5, vz);
    chk("wrcnt_sat", wr_count, 9'd511);
    do_swap("sat_swap");

    // Reset with a read in flight, then reset again partway through INIT
    rd_en = 1'b1; rd_addr = 8'd2;
    step();
    rd_en = 1'b0; rst = 1'b1;
    step();
    chk("rstflt_vld", rd_valid, 1'b0);
    chk("rstflt_bank", bank_sel, 1'b0);
    chk("rstflt_ready", ready, 1'b0);
    chk("rstflt_err", err_oob, 1'b0);
    chk("rstflt_wrcnt", wr_count, '0);
    rst = 1'b0;
    step();
    chk("rstflt_vld_after", rd_valid, 1'b0);
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("midinit_ready", ready, 1'b0);
    rst = 1'b0;
    exp_bank = 1'b0;
    wait_ready("reinit_cycles");
`ifdef VELOCITY_CELL_ZERO_INIT_EN
    do_read("post_rst_rd2", 8'd2, '0);
`else
    do_read("post_rst_rd2", 8'd2, vy);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
